// File: rtl/pulse_width_meter.sv
// Pulse width meter: synchronises an asynchronous pulse input, counts its high
// time in clock cycles and reports width, match-to-expected, overflow and glitch.
module pulse_width_meter #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned EXP_WIDTH = 10,
  parameter int unsigned TOL       = 1,
  parameter int unsigned MIN_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic [WIDTH-1:0] width_out,
  output logic             valid,
  output logic             match,
  output logic             overflow,
  output logic             glitch,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  // Match window and glitch threshold held one bit wider so nothing wraps
  localparam logic [WIDTH:0] LO    = (EXP_WIDTH > TOL) ? (WIDTH+1)'(EXP_WIDTH - TOL) : '0;
  localparam logic [WIDTH:0] HI    = (WIDTH+1)'(EXP_WIDTH + TOL);
  localparam logic [WIDTH:0] MIN_W = (WIDTH+1)'(MIN_WIDTH);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state;
  logic             s0, s1, s2;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic             ovf_acc;
  logic [WIDTH:0]   cnt_ext;

  assign rise    = s1 & ~s2;
  assign cnt_ext = {1'b0, cnt};

  // Input synchroniser; resets high so a pulse in progress at reset is never seen rising
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s0 <= a;
      s1 <= s0;
      s2 <= s1;
    end
  end

  // Measurement FSM with registered report outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      width_out <= '0;
      valid     <= 1'b0;
      match     <= 1'b0;
      overflow  <= 1'b0;
      glitch    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid  <= 1'b0;
      glitch <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt     <= WIDTH'(1);
            ovf_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (s1) begin
            // Saturate at full scale and remember that the pulse ran past it
            if (cnt == CNT_MAX) ovf_acc <= 1'b1;
            else                cnt     <= cnt + WIDTH'(1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            if ((cnt_ext < MIN_W) && !ovf_acc) begin
              glitch <= 1'b1;
            end else begin
              valid     <= 1'b1;
              width_out <= cnt;
              overflow  <= ovf_acc;
              match     <= !ovf_acc && (cnt_ext >= LO) && (cnt_ext <= HI);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: default instance plus a WIDTH=4 instance
// for saturation behaviour.
module tb_pulse_width_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a   = 1'b0;
  logic       a4  = 1'b0;

  logic [9:0] width_out;
  logic       valid, match, overflow, glitch, busy;
  logic [3:0] width_out4;
  logic       valid4, match4, overflow4, glitch4, busy4;

  int ncomp = 0;
  int nfail = 0;

  int nvalid = 0, nglitch = 0, nvalid4 = 0, nglitch4 = 0;
  int both_seen = 0;
  int wq[$];
  int mq[$];

  pulse_width_meter dut (
    .clk(clk), .rst(rst), .a(a), .width_out(width_out), .valid(valid),
    .match(match), .overflow(overflow), .glitch(glitch), .busy(busy)
  );

  pulse_width_meter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .width_out(width_out4), .valid(valid4),
    .match(match4), .overflow(overflow4), .glitch(glitch4), .busy(busy4)
  );

  always #5 clk = ~clk;

  // Strobe monitor sampled mid-cycle
  always @(negedge clk) begin
    if (valid) begin
      nvalid++;
      wq.push_back(int'(width_out));
      mq.push_back(int'(match));
    end
    if (glitch) nglitch++;
    if (valid4) nvalid4++;
    if (glitch4) nglitch4++;
    if ((valid && glitch) || (valid4 && glitch4)) both_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    nvalid = 0; nglitch = 0; nvalid4 = 0; nglitch4 = 0;
    wq.delete(); mq.delete();
  endtask

  task automatic pulse(input int len, input int gap);
    a = 1'b1; cyc(len);
    a = 1'b0; cyc(gap);
  endtask

  task automatic pulse4(input int len, input int gap);
    a4 = 1'b1; cyc(len);
    a4 = 1'b0; cyc(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 1'b0; a4 = 1'b0;
    cyc(3);
    ncomp++;
    if ({width_out, valid, match, overflow, glitch, busy} !== 15'd0) begin
      nfail++; $display("FAIL reset_outputs: got %h want 0", {width_out, valid, match, overflow, glitch, busy});
    end
    rst = 1'b0;
    clear_mon();
    cyc(5);
    ncomp++;
    if (nvalid + nglitch + nvalid4 + nglitch4 !== 0) begin
      nfail++; $display("FAIL reset_release_strobes: got %0d want 0", nvalid + nglitch + nvalid4 + nglitch4);
    end
  endtask

  task automatic test_basic();
    clear_mon();
    a = 1'b1; cyc(10);
    ncomp++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL basic_busy: got %b want 1", busy); end
    a = 1'b0;
    cyc(1);
    ncomp++;
    if (valid !== 1'b0) begin nfail++; $display("FAIL basic_early1: valid got %b want 0", valid); end
    cyc(1);
    ncomp++;
    if (valid !== 1'b0) begin nfail++; $display("FAIL basic_early2: valid got %b want 0", valid); end
    cyc(1);
    ncomp++;
    if (valid !== 1'b1) begin nfail++; $display("FAIL basic_valid: got %b want 1", valid); end
    ncomp++;
    if (width_out !== 10'd10) begin nfail++; $display("FAIL basic_width: got %0d want 10", width_out); end
    ncomp++;
    if ({match, overflow, glitch, busy} !== 4'b1000) begin
      nfail++; $display("FAIL basic_flags: got %b want 1000", {match, overflow, glitch, busy});
    end
    cyc(1);
    ncomp++;
    if (valid !== 1'b0) begin nfail++; $display("FAIL basic_one_shot: valid got %b want 0", valid); end
    cyc(3);
    ncomp++;
    if (nvalid !== 1) begin nfail++; $display("FAIL basic_count: got %0d want 1", nvalid); end
  endtask

  task automatic test_glitch();
    clear_mon();
    pulse(1, 8);
    ncomp++;
    if (nglitch !== 1) begin nfail++; $display("FAIL glitch_count: got %0d want 1", nglitch); end
    ncomp++;
    if (nvalid !== 0) begin nfail++; $display("FAIL glitch_no_valid: got %0d want 0", nvalid); end
    ncomp++;
    if (width_out !== 10'd10 || match !== 1'b1) begin
      nfail++; $display("FAIL glitch_hold: got width %0d match %b want 10 1", width_out, match);
    end
  endtask

  task automatic test_back_to_back();
    int exp_w[3] = '{10, 12, 9};
    int exp_m[3] = '{1, 0, 1};
    clear_mon();
    pulse(10, 1);
    pulse(12, 1);
    pulse(9, 8);
    ncomp++;
    if (nvalid !== 3 || nglitch !== 0) begin
      nfail++; $display("FAIL b2b_count: got %0d valid %0d glitch want 3 0", nvalid, nglitch);
    end
    for (int i = 0; i < 3; i++) begin
      ncomp++;
      if (wq.size() <= i || wq[i] !== exp_w[i] || mq[i] !== exp_m[i]) begin
        nfail++;
        $display("FAIL b2b_pulse%0d: got width %0d match %0d want %0d %0d", i,
                 (wq.size() > i) ? wq[i] : -1, (mq.size() > i) ? mq[i] : -1, exp_w[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_boundary();
    int lens[4]  = '{11, 8, 2, 3};
    int exp_m[4] = '{1, 0, 0, 0};
    clear_mon();
    for (int i = 0; i < 4; i++) pulse(lens[i], 6);
    ncomp++;
    if (nvalid !== 4 || nglitch !== 0) begin
      nfail++; $display("FAIL bound_count: got %0d valid %0d glitch want 4 0", nvalid, nglitch);
    end
    for (int i = 0; i < 4; i++) begin
      ncomp++;
      if (wq.size() <= i || wq[i] !== lens[i] || mq[i] !== exp_m[i]) begin
        nfail++;
        $display("FAIL bound_pulse%0d: got width %0d match %0d want %0d %0d", i,
                 (wq.size() > i) ? wq[i] : -1, (mq.size() > i) ? mq[i] : -1, lens[i], exp_m[i]);
      end
    end
  endtask

  task automatic test_saturation();
    clear_mon();
    pulse4(10, 6);
    ncomp++;
    if (width_out4 !== 4'd10 || match4 !== 1'b1 || overflow4 !== 1'b0) begin
      nfail++; $display("FAIL sat_10: got %0d m%b o%b want 10 m1 o0", width_out4, match4, overflow4);
    end
    pulse4(15, 6);
    ncomp++;
    if (width_out4 !== 4'd15 || overflow4 !== 1'b0 || match4 !== 1'b0) begin
      nfail++; $display("FAIL sat_15: got %0d m%b o%b want 15 m0 o0", width_out4, match4, overflow4);
    end
    pulse4(20, 6);
    ncomp++;
    if (width_out4 !== 4'd15 || overflow4 !== 1'b1 || match4 !== 1'b0) begin
      nfail++; $display("FAIL sat_20: got %0d m%b o%b want 15 m0 o1", width_out4, match4, overflow4);
    end
    pulse4(16, 6);
    ncomp++;
    if (width_out4 !== 4'd15 || overflow4 !== 1'b1) begin
      nfail++; $display("FAIL sat_16: got %0d o%b want 15 o1", width_out4, overflow4);
    end
    ncomp++;
    if (nvalid4 !== 4 || nglitch4 !== 0) begin
      nfail++; $display("FAIL sat_count: got %0d valid %0d glitch want 4 0", nvalid4, nglitch4);
    end
  endtask

  task automatic test_reset_high();
    a = 1'b1;
    rst = 1'b1; cyc(2);
    rst = 1'b0;
    clear_mon();
    cyc(5);
    a = 1'b0; cyc(8);
    ncomp++;
    if (nvalid !== 0 || nglitch !== 0) begin
      nfail++; $display("FAIL rsthigh_ignored: got %0d valid %0d glitch want 0 0", nvalid, nglitch);
    end
    pulse(10, 6);
    ncomp++;
    if (nvalid !== 1 || width_out !== 10'd10) begin
      nfail++; $display("FAIL rsthigh_next: got %0d valid width %0d want 1 10", nvalid, width_out);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    a = 1'b1; cyc(3);
    ncomp++;
    if (busy !== 1'b1) begin nfail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst = 1'b1; cyc(1);
    ncomp++;
    if ({width_out, valid, match, overflow, glitch, busy} !== 15'd0) begin
      nfail++; $display("FAIL rstmid_outputs: got %h want 0", {width_out, valid, match, overflow, glitch, busy});
    end
    rst = 1'b0;
    cyc(6);
    a = 1'b0; cyc(8);
    ncomp++;
    if (nvalid !== 0 || nglitch !== 0 || busy !== 1'b0) begin
      nfail++; $display("FAIL rstmid_ignored: got %0d valid %0d glitch busy %b want 0 0 0", nvalid, nglitch, busy);
    end
  endtask

  task automatic test_exclusive();
    ncomp++;
    if (both_seen !== 0) begin nfail++; $display("FAIL valid_glitch_overlap: got %0d want 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_boundary();
    test_saturation();
    test_reset_high();
    test_reset_mid();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
